pes_elc_scan: RTL

- Parametrised successor to the single-request elevator controller.
- Supports NUM_FLOORS floors and latches any number of concurrent floor requests into a pending mask.
- Services requests in SCAN (sweep) order, with timed floor travel, a timed door, an obstruction interlock (over_time) and an overload interlock (over_weight).
- Sits between the floor/cabin button decoders and the motor/door drivers.

---
 rtl/pes_elc_scan.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pes_elc_scan.sv
// rtl/pes_elc_scan.sv - SCAN-order multi-request elevator controller with door and overload interlocks
module pes_elc_scan #(
    parameter int NUM_FLOORS    = 8,
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] request_floor,
    input  logic [NUM_FLOORS-1:0] in_current_floor,
    input  logic                  over_time,
    input  logic                  over_weight,
    output logic                  direction,
    output logic [NUM_FLOORS-1:0] out_current_floor,
    output logic                  complete,
    output logic                  door_open,
    output logic                  moving,
    output logic                  door_alert,
    output logic                  weight_alert,
    output logic [NUM_FLOORS-1:0] pending
);

    localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
    localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    localparam logic [TW-1:0] TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MOVING,
        S_ARRIVE,
        S_DOOR_OPEN
    } state_t;

    state_t                state;
    logic [TW-1:0]         travel_cnt;
    logic [DW-1:0]         door_cnt;

    logic [NUM_FLOORS-1:0] pend_in;
    logic [NUM_FLOORS-1:0] below_mask;
    logic [NUM_FLOORS-1:0] above_mask;
    logic [NUM_FLOORS-1:0] clear_mask;
    logic [NUM_FLOORS-1:0] shifted;
    logic                  ahead;
    logic                  at_req;
    logic                  can_shift;
    logic                  deciding;
    logic                  start_onehot;

    // Requests arriving this cycle take part in this cycle's decision.
    assign pend_in    = pending | request_floor;
    assign below_mask = out_current_floor - 1'b1;
    assign above_mask = ~(out_current_floor | below_mask);
    assign ahead      = direction ? |(pend_in & above_mask) : |(pend_in & below_mask);
    assign at_req     = |(pend_in & out_current_floor);
    assign deciding   = (state == S_IDLE) || (state == S_ARRIVE);

    // The open floor is absorbed on door entry and for the whole time the door is open.
    assign clear_mask = ((deciding && at_req) || (state == S_DOOR_OPEN)) ? out_current_floor
                                                                        : '0;

    assign shifted   = direction ? (out_current_floor << 1) : (out_current_floor >> 1);
    assign can_shift = direction ? ~out_current_floor[NUM_FLOORS-1] : ~out_current_floor[0];

    assign start_onehot = (in_current_floor != '0) &&
                          ((in_current_floor & (in_current_floor - 1'b1)) == '0);

    assign door_open = (state == S_DOOR_OPEN);
    assign moving    = (state == S_MOVING);

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= S_IDLE;
            pending           <= '0;
            direction         <= 1'b1;
            complete          <= 1'b0;
            door_alert        <= 1'b0;
            weight_alert      <= 1'b0;
            travel_cnt        <= '0;
            door_cnt          <= '0;
            out_current_floor <= start_onehot ? in_current_floor
                                              : NUM_FLOORS'(1);
        end else begin
            pending      <= pend_in & ~clear_mask;
            complete     <= 1'b0;
            door_alert   <= over_time & (state == S_DOOR_OPEN);
            weight_alert <= over_weight & (state == S_DOOR_OPEN);

            case (state)
                S_IDLE, S_ARRIVE: begin
                    if (at_req) begin
                        state    <= S_DOOR_OPEN;
                        door_cnt <= DOOR_LOAD;
                        complete <= 1'b1;
                    end else if (pend_in != '0) begin
                        // Nothing ahead means everything outstanding is behind: reverse.
                        if (!ahead)
                            direction <= ~direction;
                        state      <= S_MOVING;
                        travel_cnt <= TRAVEL_LOAD;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_MOVING: begin
                    if (travel_cnt == '0) begin
                        if (can_shift)
                            out_current_floor <= shifted;
                        state <= S_ARRIVE;
                    end else begin
                        travel_cnt <= travel_cnt - 1'b1;
                    end
                end
                S_DOOR_OPEN: begin
                    if (over_time || over_weight)
                        door_cnt <= DOOR_LOAD;
                    else if (door_cnt == '0)
                        state <= S_IDLE;
                    else
                        door_cnt <= door_cnt - 1'b1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
